// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue: fetches sequential instruction words from memory
// into a small circular FIFO and issues them one at a time to decode.
//
// Ports
//   clock          rising-edge clock for all state
//   resetN         synchronous active-low reset
//   memReq/memAddr instruction-memory read request and word address (registered)
//   memReady       one-cycle strobe: memData is valid for the outstanding request
//   memData        returned instruction word
//   redirectValid  branch/jump redirect strobe; flushes the queue
//   redirectPc     new word-address PC loaded on redirect
//   decodeReady    decode can accept an instruction
//   decodePulse    one-cycle issue strobe (registered)
//   instr/pcNumber issued instruction word and its word-address PC (registered)
//   available      instr/pcNumber hold a valid issued instruction (registered)
//   queueCount     current FIFO occupancy, 0..DEPTH (registered)
module instruction_fetch_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      resetN,
  output logic                      memReq,
  output logic [31:0]               memAddr,
  input  logic                      memReady,
  input  logic [31:0]               memData,
  input  logic                      redirectValid,
  input  logic [31:0]               redirectPc,
  input  logic                      decodeReady,
  output logic                      decodePulse,
  output logic [31:0]               instr,
  output logic [31:0]               pcNumber,
  output logic                      available,
  output logic [$clog2(DEPTH):0]    queueCount
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t          state;
  logic [31:0]     fetch_pc;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [31:0]     q_instr [DEPTH];
  logic [31:0]     q_pc    [DEPTH];

  logic            push_c;
  logic            pop_c;
  logic            fetch_c;

  // Accept returned data only for a live request; a redirect kills it.
  assign push_c  = (state == BUSY) && memReady && !redirectValid;

  // Pop only from entries already registered (no bypass), and never on
  // back-to-back cycles so decode sees a rising edge per instruction.
  assign pop_c   = (queueCount != '0) && decodeReady && !redirectValid && !decodePulse;

  // Nothing is in flight while IDLE, so occupancy alone bounds the fetch.
  assign fetch_c = (state == IDLE) && (queueCount < CW'(DEPTH)) && !redirectValid;

  // Queue storage; contents need no reset because pointers/count gate reads.
  always_ff @(posedge clock) begin
    if (resetN && push_c) begin
      q_instr[wr_ptr] <= memData;
      q_pc[wr_ptr]    <= fetch_pc;
    end
  end

  // Pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      queueCount <= '0;
    end else if (redirectValid) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      queueCount <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_c, pop_c})
        2'b10:   queueCount <= queueCount + CW'(1);
        2'b01:   queueCount <= queueCount - CW'(1);
        default: queueCount <= queueCount;
      endcase
    end
  end

  // Issue stage: registers the popped head towards decode.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      decodePulse <= 1'b0;
      available   <= 1'b0;
      instr       <= '0;
      pcNumber    <= '0;
    end else if (redirectValid) begin
      decodePulse <= 1'b0;
      available   <= 1'b0;
    end else if (pop_c) begin
      decodePulse <= 1'b1;
      available   <= 1'b1;
      instr       <= q_instr[rd_ptr];
      pcNumber    <= q_pc[rd_ptr];
    end else begin
      decodePulse <= 1'b0;
    end
  end

  // Fetch FSM. DISCARD waits out a request whose data a redirect made stale;
  // memReq/memAddr stay held until that memory response arrives.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      state    <= IDLE;
      fetch_pc <= '0;
      memReq   <= 1'b0;
      memAddr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (redirectValid) begin
            fetch_pc <= redirectPc;
          end else if (fetch_c) begin
            state   <= BUSY;
            memReq  <= 1'b1;
            memAddr <= fetch_pc;
          end
        end
        BUSY: begin
          if (redirectValid) begin
            fetch_pc <= redirectPc;
            // A response landing with the redirect closes the request here.
            if (memReady) begin
              state  <= IDLE;
              memReq <= 1'b0;
            end else begin
              state  <= DISCARD;
            end
          end else if (memReady) begin
            fetch_pc <= fetch_pc + 32'd1;
            state    <= IDLE;
            memReq   <= 1'b0;
          end
        end
        DISCARD: begin
          if (redirectValid) fetch_pc <= redirectPc;
          if (memReady) begin
            state  <= IDLE;
            memReq <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          memReq <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
module tb_instruction_fetch_queue;

  localparam int unsigned DEPTH = 4;

  logic        clock;
  logic        resetN;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memReady;
  logic [31:0] memData;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        decodeReady;
  logic        decodePulse;
  logic [31:0] instr;
  logic [31:0] pcNumber;
  logic        available;
  logic [$clog2(DEPTH):0] queueCount;

  int tests = 0;
  int fails = 0;
  int nfetch;

  instruction_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clock         (clock),
    .resetN        (resetN),
    .memReq        (memReq),
    .memAddr       (memAddr),
    .memReady      (memReady),
    .memData       (memData),
    .redirectValid (redirectValid),
    .redirectPc    (redirectPc),
    .decodeReady   (decodeReady),
    .decodePulse   (decodePulse),
    .instr         (instr),
    .pcNumber      (pcNumber),
    .available     (available),
    .queueCount    (queueCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " memReq"},      32'(memReq),      32'd0);
    check({tag, " memAddr"},     memAddr,          32'd0);
    check({tag, " decodePulse"}, 32'(decodePulse), 32'd0);
    check({tag, " available"},   32'(available),   32'd0);
    check({tag, " instr"},       instr,            32'd0);
    check({tag, " pcNumber"},    pcNumber,         32'd0);
    check({tag, " queueCount"},  32'(queueCount),  32'd0);
  endtask

  initial begin
    resetN        = 1'b0;
    memReady      = 1'b0;
    memData       = '0;
    redirectValid = 1'b0;
    redirectPc    = '0;
    decodeReady   = 1'b1;

    // Reset state
    tick();
    tick();
    check_reset_values("reset");

    // Two fetches, memory answers two cycles after each request
    resetN = 1'b1;
    tick();                                             // E1
    check("e1 memReq",  32'(memReq), 32'd1);
    check("e1 memAddr", memAddr,     32'd0);
    tick();                                             // E2
    memReady = 1'b1; memData = 32'h0000_0013;
    tick();                                             // E3 push
    memReady = 1'b0;
    check("e3 memReq",     32'(memReq),     32'd0);
    check("e3 queueCount", 32'(queueCount), 32'd1);
    check("e3 noPulse",    32'(decodePulse), 32'd0);
    tick();                                             // E4 issue + fetch 1
    check("e4 decodePulse", 32'(decodePulse), 32'd1);
    check("e4 instr",       instr,            32'h0000_0013);
    check("e4 pcNumber",    pcNumber,         32'd0);
    check("e4 available",   32'(available),   32'd1);
    check("e4 memAddr",     memAddr,          32'd1);
    tick();                                             // E5
    check("e5 decodePulse", 32'(decodePulse), 32'd0);
    check("e5 available",   32'(available),   32'd1);
    memReady = 1'b1; memData = 32'h0010_0093;
    tick();                                             // E6 push
    memReady = 1'b0;
    tick();                                             // E7 issue + fetch 2
    check("e7 decodePulse", 32'(decodePulse), 32'd1);
    check("e7 instr",       instr,            32'h0010_0093);
    check("e7 pcNumber",    pcNumber,         32'd1);
    check("e7 memAddr",     memAddr,          32'd2);

    // Decode stalled, memory always ready: queue fills to DEPTH
    decodeReady = 1'b0;
    memReady    = 1'b1;
    nfetch      = 1;                                    // request for addr 2 already out
    for (int i = 0; i < 16; i++) begin
      memData = 32'hA000_0000 | memAddr;
      tick();
      if (memReq) nfetch++;
    end
    memReady = 1'b0;
    check("fill fetches",    32'(nfetch),     32'(DEPTH));
    check("fill queueCount", 32'(queueCount), 32'(DEPTH));
    check("fill memReq",     32'(memReq),     32'd0);
    check("fill memAddr",    memAddr,         32'd5);

    // Resume: one pulse every two cycles, in fetch order
    decodeReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("drain pulse",    32'(decodePulse), 32'd1);
      check("drain instr",    instr,            32'hA000_0002 + 32'(i));
      check("drain pcNumber", pcNumber,         32'd2 + 32'(i));
      tick();
      check("drain gap",      32'(decodePulse), 32'd0);
    end
    check("drain queueCount", 32'(queueCount), 32'd0);
    check("drain memReq",     32'(memReq),     32'd1);
    check("drain memAddr",    memAddr,         32'd6);

    // Redirect while BUSY: flush, stale response dropped, refetch at 0x40
    redirectValid = 1'b1; redirectPc = 32'h0000_0040;
    tick();                                             // G1
    redirectValid = 1'b0;
    check("g1 queueCount", 32'(queueCount), 32'd0);
    check("g1 available",  32'(available),  32'd0);
    check("g1 memReq",     32'(memReq),     32'd1);
    memReady = 1'b1; memData = 32'hDEAD_BEEF;
    tick();                                             // G2 stale data
    memReady = 1'b0;
    check("g2 memReq",     32'(memReq),     32'd0);
    check("g2 queueCount", 32'(queueCount), 32'd0);
    tick();                                             // G3
    check("g3 memAddr",    memAddr,          32'h0000_0040);
    check("g3 memReq",     32'(memReq),      32'd1);
    check("g3 noPulse",    32'(decodePulse), 32'd0);
    memReady = 1'b1; memData = 32'h1111_1111;
    tick();                                             // G4 push
    memReady = 1'b0;
    tick();                                             // G5 issue
    check("g5 pulse",      32'(decodePulse), 32'd1);
    check("g5 instr",      instr,            32'h1111_1111);
    check("g5 pcNumber",   pcNumber,         32'h0000_0040);
    memReady = 1'b1; memData = 32'h2222_2222;
    tick();                                             // G6 push
    memReady = 1'b0;

    // Redirect in the cycle a pop would happen
    redirectValid = 1'b1; redirectPc = 32'hFFFF_FFFF;
    tick();                                             // G7
    redirectValid = 1'b0;
    check("g7 noPulse",    32'(decodePulse), 32'd0);
    check("g7 available",  32'(available),   32'd0);
    check("g7 queueCount", 32'(queueCount),  32'd0);
    check("g7 memReq",     32'(memReq),      32'd0);

    // PC wrap 0xFFFFFFFF -> 0
    tick();                                             // G8
    check("g8 memAddr",    memAddr, 32'hFFFF_FFFF);
    memReady = 1'b1; memData = 32'h3333_3333;
    tick();                                             // G9 push
    memReady = 1'b0;
    tick();                                             // G10 issue
    check("g10 pulse",     32'(decodePulse), 32'd1);
    check("g10 instr",     instr,            32'h3333_3333);
    check("g10 pcNumber",  pcNumber,         32'hFFFF_FFFF);
    check("g10 memAddr",   memAddr,          32'd0);
    memReady = 1'b1; memData = 32'h4444_4444;
    tick();                                             // G11 push
    memReady = 1'b0;
    tick();                                             // G12 issue
    check("g12 instr",     instr,    32'h4444_4444);
    check("g12 pcNumber",  pcNumber, 32'd0);
    check("g12 memAddr",   memAddr,  32'd1);

    // Fill to three entries with a request outstanding, then reset
    decodeReady = 1'b0;
    memReady = 1'b1; memData = 32'h5555_5555;
    for (int i = 0; i < 5; i++) tick();                 // G13..G17
    memReady = 1'b0;
    tick();                                             // G18
    check("pre-reset queueCount", 32'(queueCount), 32'd3);
    check("pre-reset memReq",     32'(memReq),     32'd1);
    check("pre-reset memAddr",    memAddr,         32'd4);
    resetN = 1'b0;
    tick();
    check_reset_values("midbusy reset");

    // Late memReady after reset release is ignored
    resetN = 1'b1;
    memReady = 1'b1; memData = 32'h6666_6666;
    tick();
    memReady = 1'b0;
    check("post-reset queueCount", 32'(queueCount), 32'd0);
    check("post-reset memReq",     32'(memReq),     32'd1);
    check("post-reset memAddr",    memAddr,         32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_queue.md
INSTRUCTION_FETCH_QUEUE -- requirements
Module: instruction_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of queue entries (power of two, 2..16).
REQ-002 SHALL have port clock, input, 1, meaning the single clock; all state updates on the rising edge.
REQ-003 SHALL have port resetN, input, 1, meaning reset: one clock, reset synchronous and active-low.
REQ-004 SHALL have port memReq, output, 1, meaning instruction-memory read request.
REQ-005 SHALL have port memAddr, output, 32, meaning word address of the request.
REQ-006 SHALL have port memReady, input, 1, meaning memData valid for the outstanding request, one-cycle strobe.
REQ-007 SHALL have port memData, input, 32, meaning instruction word returned.
REQ-008 SHALL have port redirectValid, input, 1, meaning branch/jump redirect strobe.
REQ-009 SHALL have port redirectPc, input, 32, meaning new word-address PC.
REQ-010 SHALL have port decodeReady, input, 1, meaning downstream decode/ROB can accept an instruction.
REQ-011 SHALL have port decodePulse, output, 1, meaning one-cycle issue strobe to decode.
REQ-012 SHALL have port instr, output, 32, meaning issued instruction word.
REQ-013 SHALL have port pcNumber, output, 32, meaning word-address PC of the issued instruction.
REQ-014 SHALL have port available, output, 1, meaning instr/pcNumber hold a valid issued instruction.
REQ-015 SHALL have port queueCount, output, log2(DEPTH)+1, meaning current occupancy.

Function
REQ-016 SHALL hold a circular FIFO of {instr, pc} entries with wrapping read/write pointers and count 0..DEPTH.
REQ-017 SHALL run fetch FSM IDLE/BUSY/DISCARD; fetchPc is a 32-bit word address that wraps 0xFFFFFFFF->0.
REQ-018 IDLE: if count plus in-flight < DEPTH and no redirect, SHALL assert memReq with memAddr=fetchPc and go BUSY next cycle.
REQ-019 BUSY: SHALL hold memReq=1 and memAddr stable until memReady; on memReady SHALL push {memData, fetchPc}, increment fetchPc, return to IDLE.
REQ-020 BUSY with redirectValid: SHALL go DISCARD, keep memReq held; on memReady in DISCARD SHALL drop data and go IDLE.
REQ-021 redirectValid in any state SHALL flush the queue (count=0), load fetchPc=redirectPc, and suppress push and issue that cycle.
REQ-022 Issue: when count>0, decodeReady=1, no redirect, and decodePulse was 0 last cycle, SHALL pop head, register instr/pcNumber, set decodePulse=1 and available=1 next cycle.
REQ-023 decodePulse SHALL be high exactly one cycle and low at least one cycle between pulses (rising edge per instruction); available SHALL stay 1 until flush or reset.
REQ-024 Simultaneous push and pop SHALL keep count unchanged; push when full SHALL not occur by construction of REQ-018.
REQ-025 Pushed entry SHALL NOT bypass; earliest issue is the cycle after the push.
REQ-026 Instructions SHALL issue in fetch order with pcNumber equal to the fetch address.

Reset
REQ-027 resetN=0 at a clock edge SHALL set state IDLE, fetchPc=0, pointers/count=0, memReq=0, memAddr=0, decodePulse=0, available=0, instr=0, pcNumber=0.
REQ-028 Reset during BUSY SHALL abandon the request; a memReady arriving after reset release while IDLE SHALL be ignored.

Verification
REQ-029 Reset release, memReady 2 cycles after each memReq with data 0x00000013,0x00100093 -> memAddr 0 then 1; pulses with pcNumber 0,1 and those instr values.
REQ-030 decodeReady=0, memory always ready -> exactly DEPTH fetches, queueCount=DEPTH, memReq then low; raising decodeReady resumes one pulse every two cycles.
REQ-031 redirectValid with redirectPc=0x40 while BUSY -> queueCount=0 next cycle, stale memReady data never issued, next memAddr=0x40.
REQ-032 Redirect in the cycle a pop would occur -> no decodePulse that cycle, available=0 next cycle.
REQ-033 fetchPc=0xFFFFFFFF via redirect -> fetch 0xFFFFFFFF then 0x00000000, pcNumber wraps accordingly.
REQ-034 resetN=0 asserted mid-BUSY with queueCount=3 -> all outputs at REQ-027 values after the edge.
